// File: rtl/fifo_axis_pkg.sv
// Shared types and defaults for the FIFO to AXI-Stream bridge.
// Holds the skid buffer state enum and default geometry.
package fifo_axis_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 24;
  localparam int unsigned DEF_PKT_LEN    = 31;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-slot output/skid register buffer feeding an AXI-Stream master.
// full_o is a pure register decode so upstream pops never see tready.
module axis_skid_buffer
  import fifo_axis_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DATA_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             xfer;

  assign xfer        = out_valid_o & out_ready_i;
  assign full_o      = (state_q == TWO);
  assign out_valid_o = (state_q == ONE) | (state_q == TWO);
  assign out_data_o  = out_q;

  // Next state and slot loads.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (push_i) begin
          out_d   = push_data_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push_i && xfer) begin
          out_d = push_data_i;
        end else if (push_i) begin
          skid_d  = push_data_i;
          state_d = TWO;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (xfer) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and slot registers; reset drops any held beats.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/fifo_axis_bridge.sv
// Pops a FWFT sync FIFO into an AXI-Stream master via a skid buffer.
// Optional FIFO_AXIS_TLAST_EN adds the packet counter, tlast and beat_cnt.
module fifo_axis_bridge
  import fifo_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PKT_LEN    = DEF_PKT_LEN,
  parameter int unsigned CNT_WIDTH  = $clog2(PKT_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty_n,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata
`ifdef FIFO_AXIS_TLAST_EN
  ,
  output logic                  m_axis_tlast,
  output logic [CNT_WIDTH-1:0]  beat_cnt
`endif
);

  if (PKT_LEN < 1 || PKT_LEN > 65535 ||
      (2 ** CNT_WIDTH) < PKT_LEN) begin : g_bad_cfg
    $error("fifo_axis_bridge: bad PKT_LEN/CNT_WIDTH");
  end

`ifdef FIFO_AXIS_TLAST_EN
  localparam int unsigned BW = DATA_WIDTH + 1;
`else
  localparam int unsigned BW = DATA_WIDTH;
`endif

  logic          pop;
  logic          full;
  logic [BW-1:0] push_w;
  logic [BW-1:0] out_w;

  assign pop        = reset_n & fifo_empty_n & ~full;
  assign fifo_rd_en = pop;

`ifdef FIFO_AXIS_TLAST_EN
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(PKT_LEN - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 last_w;

  assign last_w       = (cnt_q == CNT_LAST);
  assign push_w       = {last_w, fifo_rd_data};
  assign m_axis_tlast = out_w[DATA_WIDTH];
  assign m_axis_tdata = out_w[DATA_WIDTH-1:0];
  assign beat_cnt     = cnt_q;

  // Beat counter advances per pop, wrapping at packet end.
  always_comb begin
    cnt_d = cnt_q;
    if (pop) begin
      cnt_d = last_w ? '0 : cnt_q + 1'b1;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign push_w       = fifo_rd_data;
  assign m_axis_tdata = out_w;
`endif

  axis_skid_buffer #(
    .WIDTH (BW)
  ) u_skid (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .push_i      (pop),
    .push_data_i (push_w),
    .full_o      (full),
    .out_valid_o (m_axis_tvalid),
    .out_ready_i (m_axis_tready),
    .out_data_o  (out_w)
  );

endmodule

// File: tb/tb_fifo_axis_bridge.sv
// Randomized self-checking bench for fifo_axis_bridge.
// Reference: queue of upstream words plus queue of in-flight beats.
module tb_fifo_axis_bridge;

  localparam int DW = 24;
  localparam int PL = 31;
  localparam int CW = $clog2(PL + 1);

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_empty_n;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
`ifdef FIFO_AXIS_TLAST_EN
  logic          m_axis_tlast;
  logic [CW-1:0] beat_cnt;
`endif

  fifo_axis_bridge #(
    .DATA_WIDTH (DW),
    .PKT_LEN    (PL)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_empty_n  (fifo_empty_n),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata)
`ifdef FIFO_AXIS_TLAST_EN
    ,
    .m_axis_tlast  (m_axis_tlast),
    .beat_cnt      (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] src[$];
  beat_t         exp_q[$];
  int            pop_idx;
  bit            zero_out;
  int            n_chk, n_fail;
  int            cyc, beats, pops, lasts;
  int            first_cyc, last_cyc;
  logic [DW-1:0] first_data, last_data;
  int            word;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, want, cyc);
    end
  endtask

  task automatic step(input bit rdy, input bit av, input bit rstn);
    bit    pop, xf;
    beat_t b;
    @(negedge clk);
    reset_n       = rstn;
    m_axis_tready = rdy;
    fifo_empty_n  = av && (src.size() != 0);
    fifo_rd_data  = (src.size() != 0) ? src[0] : DW'($urandom);
    #1;
    pop = rstn && fifo_empty_n && (exp_q.size() < 2);
    xf  = (exp_q.size() != 0) && rdy;
    chk("rd_en", fifo_rd_en, pop);
    chk("tvalid", m_axis_tvalid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("tdata", m_axis_tdata, exp_q[0].data);
`ifdef FIFO_AXIS_TLAST_EN
      chk("tlast", m_axis_tlast, exp_q[0].last);
`endif
    end else if (zero_out) begin
      chk("tdata_rst", m_axis_tdata, 0);
`ifdef FIFO_AXIS_TLAST_EN
      chk("tlast_rst", m_axis_tlast, 0);
`endif
    end
`ifdef FIFO_AXIS_TLAST_EN
    chk("beat_cnt", beat_cnt, pop_idx % PL);
`endif
    @(posedge clk);
    cyc++;
    if (!rstn) begin
      exp_q.delete();
      pop_idx  = 0;
      zero_out = 1;
    end else begin
      if (xf) begin
        b = exp_q.pop_front();
        if (beats == 0) begin
          first_cyc  = cyc;
          first_data = b.data;
        end
        last_cyc = cyc;
        beats++;
        if (b.last) begin
          lasts++;
          last_data = b.data;
        end
      end
      if (pop) begin
        b.data = src.pop_front();
        b.last = ((pop_idx % PL) == PL - 1);
        exp_q.push_back(b);
        pop_idx++;
        pops++;
        zero_out = 0;
      end
    end
  endtask

  task automatic clr_stats();
    beats = 0;
    pops  = 0;
    lasts = 0;
  endtask

  task automatic fill(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) src.push_back(DW'(i));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((src.size() != 0 || exp_q.size() != 0) && n < 500) begin
      step(1'b1, 1'b1, 1'b1);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    pop_idx = 0; zero_out = 1; word = 1000;
    reset_n = 1'b0; m_axis_tready = 1'b0;
    fifo_empty_n = 1'b0; fifo_rd_data = '0;
    repeat (2) @(posedge clk);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);

    // 31-word packet at full rate.
    clr_stats();
    fill(1, 31);
    repeat (35) step(1'b1, 1'b1, 1'b1);
    chk("p37_beats", beats, 31);
    chk("p37_span", last_cyc - first_cyc, 30);
    chk("p37_first", first_data, 1);
`ifdef FIFO_AXIS_TLAST_EN
    chk("p37_lasts", lasts, 1);
    chk("p37_lastdata", last_data, 31);
`endif

    // Backpressure fills both slots, then releases.
    clr_stats();
    fill(1, 4);
    repeat (5) step(1'b0, 1'b1, 1'b1);
    chk("p38_pops", pops, 2);
    chk("p38_held", exp_q.size(), 2);
    clr_stats();
    repeat (6) step(1'b1, 1'b1, 1'b1);
    chk("p38_beats", beats, 4);
    chk("p38_span", last_cyc - first_cyc, 3);
    drain();

    // Toggling tready over two packets.
    clr_stats();
    pop_idx = pop_idx % PL;
    fill(1, 62);
    for (int i = 0; i < 200 && beats < 62; i++)
      step((i % 2) == 0, 1'b1, 1'b1);
    chk("p39_beats", beats, 62);
    drain();

    // Reset while both slots hold beats 5 and 6.
    clr_stats();
    fill(5, 40);
    repeat (3) step(1'b0, 1'b1, 1'b1);
    chk("p40_held", exp_q.size(), 2);
    step(1'b0, 1'b1, 1'b0);
    clr_stats();
    drain();
    chk("p40_first", first_data, 7);
    chk("p40_beats", beats, 34);
`ifdef FIFO_AXIS_TLAST_EN
    chk("p40_lastdata", last_data, 37);
`endif

    // Intermittent FIFO availability.
    clr_stats();
    fill(100, 105);
    for (int i = 0; i < 12; i++)
      step(1'b1, (i % 3) != 1, 1'b1);
    chk("p41_beats", beats, 6);
    drain();

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      while (src.size() < 4) begin
        src.push_back(DW'($urandom));
        word++;
      end
      step(($urandom % 4) != 0, ($urandom % 3) != 0,
           ($urandom % 97) != 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_axis_bridge.md
FIFO_AXIS_BRIDGE -- requirements
Module: fifo_axis_bridge

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, the width of a FIFO word and of the AXI-Stream beat.
REQ-002 The block SHALL have parameter PKT_LEN, default 31, the number of beats per packet (legal range 1..65535).
REQ-003 The block SHALL have parameter CNT_WIDTH, default $clog2(PKT_LEN+1), the width of the beat counter.
REQ-004 The block SHALL have a single clock and a synchronous, active-low reset.
REQ-005 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-006 reset_n  input  1  synchronous active-low reset.
REQ-007 fifo_rd_en  output  1  pops the upstream sync_fifo_controller this cycle.
REQ-008 fifo_rd_data  input  DATA_WIDTH  first-word-fall-through head word, valid while fifo_empty_n=1.
REQ-009 fifo_empty_n  input  1  upstream FIFO holds at least one word.
REQ-010 m_axis_tvalid  output  1  beat valid.
REQ-011 m_axis_tready  input  1  downstream accepts the beat.
REQ-012 m_axis_tdata  output  DATA_WIDTH  beat payload.
REQ-013 m_axis_tlast  output  1  last beat of a packet (FIFO_AXIS_TLAST_EN only).
REQ-014 beat_cnt  output  CNT_WIDTH  words popped in the current packet (FIFO_AXIS_TLAST_EN only).

Function
REQ-015 The block SHALL implement a two-slot register buffer, output slot OUT and skid slot SKID, with states EMPTY, ONE and TWO.
REQ-016 fifo_rd_en SHALL be fifo_empty_n AND (state != TWO), with no combinational path from m_axis_tready.
REQ-017 A pop SHALL capture fifo_rd_data, plus its tlast flag, at the same edge.
REQ-018 m_axis_tvalid SHALL be 1 exactly when the state is ONE or TWO; OUT SHALL drive tdata and tlast.
REQ-019 A beat SHALL be transferred when tvalid=1 and tready=1.
REQ-020 EMPTY transitions: pop -> ONE (into OUT); no pop -> EMPTY.
REQ-021 ONE transitions: pop with transfer -> ONE (OUT reloaded); pop without transfer -> TWO (into SKID); transfer only -> EMPTY; neither -> ONE.
REQ-022 TWO transitions: transfer -> ONE (SKID moves to OUT); no transfer -> TWO. No pop SHALL occur in TWO.
REQ-023 While tvalid=1 and tready=0, tdata and tlast SHALL remain stable.
REQ-024 Latency SHALL be one cycle from pop to tvalid; sustained throughput SHALL be one beat per cycle while the FIFO is non-empty and tready=1.
REQ-025 Beats SHALL leave in strict FIFO order; no word SHALL be dropped or duplicated.
REQ-026 fifo_empty_n=0 SHALL cause no pop, and the buffered beats SHALL drain normally.
REQ-027 The beat counter SHALL increment on each pop and wrap from PKT_LEN-1 to 0.
REQ-028 The popped word SHALL carry tlast=1 iff beat_cnt==PKT_LEN-1 at the pop; if PKT_LEN=1, every beat SHALL carry tlast=1.

Reset
REQ-029 While reset_n=0 at an edge, the state SHALL become EMPTY, beat_cnt 0, tvalid 0, tdata 0 and tlast 0.
REQ-030 fifo_rd_en SHALL be 0 during reset.
REQ-031 Buffered beats SHALL be discarded on reset mid-operation, including in state TWO.
REQ-032 Pops SHALL resume on the first cycle after release.

Configuration
REQ-033 Macro FIFO_AXIS_TLAST_EN defined: m_axis_tlast, beat_cnt and the counter SHALL be present per REQ-027/028.
REQ-034 Macro FIFO_AXIS_TLAST_EN undefined: those ports and the counter SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-035 Package fifo_axis_pkg SHALL hold the state enum (EMPTY, ONE, TWO) and the default DATA_WIDTH/PKT_LEN constants.
REQ-036 The two-slot buffer SHALL be the sub-module axis_skid_buffer; the top SHALL hold the counter and the FIFO handshake.

Verification
REQ-037 Words 1..31 queued, tready=1 -> 31 beats on 31 consecutive cycles, data 1..31, tlast only on 31, beat_cnt back to 0.
REQ-038 Words 1..4 queued, tready=0 for 5 cycles -> exactly 2 pops, state TWO, tdata=1 held stable; tready=1 -> beats 1,2,3,4 in order, no gaps after the first.
REQ-039 tready toggling 1,0,1,0 while 62 words stream -> 62 beats, order intact, tlast on beats 31 and 62.
REQ-040 reset_n=0 for 1 cycle while in state TWO (beats 5,6 held) -> tvalid=0 next cycle and beat_cnt=0; after release the next FIFO word 7 is emitted with tlast on 7+30=37.
REQ-041 fifo_empty_n pulsing 1,0,1 with tready=1 -> one beat per available word, tvalid deasserts in the gap.
REQ-042 Build without FIFO_AXIS_TLAST_EN, scenario REQ-037 -> identical tdata sequence, no tlast port.
